// File: rtl/l1d_wmu_pkg.sv
// Shared types and default geometry for the L1D store write-merge unit.
package l1d_wmu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    OPEN  = 2'd1,
    DRAIN = 2'd2
  } wmu_state_e;

  localparam int DEF_LINE_BYTES   = 32;
  localparam int DEF_WORD_BYTES   = 4;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int DEF_OFF_W        = $clog2(DEF_LINE_BYTES);
  localparam int DEF_LINE_W       = DEF_ADDR_W - DEF_OFF_W;

  // Width of a line address once the in-line byte offset is stripped.
  function automatic int line_width(input int addr_w, input int line_bytes);
    return addr_w - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/l1d_byte_lane_shifter.sv
// Places store byte lanes at their in-line offset; lanes past the line end
// land in a spill image for the following line.
module l1d_byte_lane_shifter #(
  parameter int LINE_BYTES = 32,
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = $clog2(LINE_BYTES)
) (
  input  logic [OFF_W-1:0]        off,
  input  logic [WORD_BYTES-1:0]   enable,
  input  logic [8*WORD_BYTES-1:0] data,
  output logic [8*LINE_BYTES-1:0] line_data,
  output logic [LINE_BYTES-1:0]   line_mask,
  output logic [8*LINE_BYTES-1:0] spill_data,
  output logic [LINE_BYTES-1:0]   spill_mask
);

  logic [OFF_W:0] pos;

  always_comb begin
    line_data  = '0;
    line_mask  = '0;
    spill_data = '0;
    spill_mask = '0;
    pos        = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      pos = {1'b0, off} + (OFF_W+1)'(k);
      // Since pos < 2*LINE_BYTES, the low bits are the byte index in either line.
      if (enable[k]) begin
        if (!pos[OFF_W]) begin
          line_data[{pos[OFF_W-1:0], 3'b000} +: 8] = data[8*k +: 8];
          line_mask[pos[OFF_W-1:0]]                = 1'b1;
        end else begin
          spill_data[{pos[OFF_W-1:0], 3'b000} +: 8] = data[8*k +: 8];
          spill_mask[pos[OFF_W-1:0]]                = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/l1d_write_merge_unit.sv
// L1D store merge stage: coalesces byte-enabled stores into one open line and
// drains masked line writes; line-crossing stores carry their tail into a spill.
//
// state | meaning
// EMPTY | no open line, any store accepted
// OPEN  | line buffered, same-line stores merge
// DRAIN | line write presented until wr_ready
module l1d_write_merge_unit
  import l1d_wmu_pkg::*;
#(
  parameter int LINE_BYTES   = DEF_LINE_BYTES,
  parameter int WORD_BYTES   = DEF_WORD_BYTES,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          st_valid,
  output logic                                          st_ready,
  input  logic [ADDR_W-1:0]                             st_addr,
  input  logic [WORD_BYTES-1:0]                         st_byte_enable,
  input  logic [8*WORD_BYTES-1:0]                       st_wdata,
  input  logic                                          flush,
  output logic                                          wr_valid,
  input  logic                                          wr_ready,
  output logic [line_width(ADDR_W, LINE_BYTES)-1:0]     wr_line_addr,
  output logic [8*LINE_BYTES-1:0]                       wr_data,
  output logic [LINE_BYTES-1:0]                         wr_byte_mask,
  output logic                                          empty
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = line_width(ADDR_W, LINE_BYTES);
  localparam int CNT_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (IDLE_TIMEOUT != 0);

  wmu_state_e              state;
  logic [8*LINE_BYTES-1:0] buf_data, spill_data, sh_data, sp_data, merged_data;
  logic [LINE_BYTES-1:0]   buf_mask, spill_mask, sh_mask, sp_mask, merged_mask;
  logic [LINE_W-1:0]       buf_line, spill_line, st_line;
  logic [OFF_W-1:0]        st_off;
  logic [CNT_W-1:0]        idle_cnt;
  logic                    wr_valid_q;
  logic                    accept, conflict, spill_new, full_new, timeout_hit, drain_trig;

  assign st_line = st_addr[ADDR_W-1:OFF_W];
  assign st_off  = st_addr[OFF_W-1:0];

  l1d_byte_lane_shifter #(
    .LINE_BYTES (LINE_BYTES),
    .WORD_BYTES (WORD_BYTES),
    .OFF_W      (OFF_W)
  ) u_shifter (
    .off        (st_off),
    .enable     (st_byte_enable),
    .data       (st_wdata),
    .line_data  (sh_data),
    .line_mask  (sh_mask),
    .spill_data (sp_data),
    .spill_mask (sp_mask)
  );

  // Newer bytes win; in EMPTY the mask is clear so this is a plain load.
  always_comb begin
    merged_data = buf_data;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (sh_mask[i]) merged_data[8*i +: 8] = sh_data[8*i +: 8];
    end
  end

  assign merged_mask = buf_mask | sh_mask;

  always_comb begin
    st_ready = 1'b0;
    if (!rst) begin
      case (state)
        EMPTY:   st_ready = 1'b1;
        OPEN:    st_ready = (st_line == buf_line);
        default: st_ready = 1'b0;
      endcase
    end
  end

  assign accept      = st_valid && st_ready;
  assign conflict    = (state == OPEN) && st_valid && !st_ready;
  assign spill_new   = accept && (|sp_mask);
  assign full_new    = accept && (&merged_mask);
  assign timeout_hit = TO_EN && !accept && (idle_cnt == TO_LAST);
  assign drain_trig  = spill_new || full_new || flush || timeout_hit || conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      wr_valid_q <= 1'b0;
      buf_data   <= '0;
      buf_mask   <= '0;
      buf_line   <= '0;
      spill_data <= '0;
      spill_mask <= '0;
      spill_line <= '0;
      idle_cnt   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            buf_data   <= merged_data;
            buf_mask   <= sh_mask;
            buf_line   <= st_line;
            spill_data <= sp_data;
            spill_mask <= sp_mask;
            spill_line <= st_line + LINE_W'(1);
            idle_cnt   <= '0;
            if (spill_new || full_new) begin
              state      <= DRAIN;
              wr_valid_q <= 1'b1;
            end else begin
              state <= OPEN;
            end
          end
        end
        OPEN: begin
          if (accept) begin
            buf_data   <= merged_data;
            buf_mask   <= merged_mask;
            spill_data <= sp_data;
            spill_mask <= sp_mask;
            spill_line <= st_line + LINE_W'(1);
            idle_cnt   <= '0;
          end else if (idle_cnt != TO_LAST) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
          if (drain_trig) begin
            state      <= DRAIN;
            wr_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            // A pending spill becomes the next open line without passing EMPTY.
            if (|spill_mask) begin
              buf_data   <= spill_data;
              buf_mask   <= spill_mask;
              buf_line   <= spill_line;
              spill_mask <= '0;
              idle_cnt   <= '0;
              state      <= OPEN;
            end else begin
              buf_mask <= '0;
              state    <= EMPTY;
            end
          end
        end
        default: begin
          state      <= EMPTY;
          wr_valid_q <= 1'b0;
          buf_mask   <= '0;
          spill_mask <= '0;
        end
      endcase
    end
  end

  assign wr_valid     = wr_valid_q;
  assign wr_data      = buf_data;
  assign wr_byte_mask = buf_mask;
  assign wr_line_addr = buf_line;
  assign empty        = (state == EMPTY);

endmodule

// File: tb/tb_l1d_write_merge_unit.sv
// Scoreboard bench for l1d_write_merge_unit: a byte-array reference model
// predicts line writes, a separate monitor checks each write handshake.
module tb_l1d_write_merge_unit;

  localparam int LB = 32;
  localparam int WB = 4;
  localparam int AW = 32;
  localparam int TO = 4;
  localparam int OFFW = 5;
  localparam int LW = AW - OFFW;
  localparam int M_EMPTY = 0;
  localparam int M_OPEN = 1;
  localparam int M_DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st_valid = 1'b0;
  logic st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [WB-1:0] st_byte_enable = '0;
  logic [8*WB-1:0] st_wdata = '0;
  logic flush = 1'b0;
  logic wr_valid;
  logic wr_ready = 1'b0;
  logic [LW-1:0] wr_line_addr;
  logic [8*LB-1:0] wr_data;
  logic [LB-1:0] wr_byte_mask;
  logic empty;

  l1d_write_merge_unit #(
    .LINE_BYTES(LB), .WORD_BYTES(WB), .ADDR_W(AW), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_byte_enable(st_byte_enable), .st_wdata(st_wdata),
    .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_line_addr(wr_line_addr), .wr_data(wr_data), .wr_byte_mask(wr_byte_mask),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0]   line;
    logic [LB-1:0]   mask;
    logic [8*LB-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte arrays for the open line and the spill line.
  int ms = M_EMPTY;
  logic [7:0] m_data[LB];
  logic [LB-1:0] m_mask = '0;
  logic [LW-1:0] m_line = '0;
  logic [7:0] s_data[LB];
  logic [LB-1:0] s_mask = '0;
  logic [LW-1:0] s_line = '0;
  int idle = 0;
  bit m_acc = 1'b0;

  task automatic chk(input string name, input logic [8*LB-1:0] act, input logic [8*LB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*LB-1:0] byte_mask(input logic [LB-1:0] m);
    logic [8*LB-1:0] r;
    for (int i = 0; i < LB; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (ms == M_EMPTY) return 1'b1;
    if (ms == M_OPEN) return st_addr[AW-1:OFFW] == m_line;
    return 1'b0;
  endfunction

  // Each enabled lane k writes byte address st_addr+k (mod 2^AW).
  function automatic void apply_store();
    logic [AW-1:0] a;
    for (int k = 0; k < WB; k++) begin
      if (st_byte_enable[k]) begin
        a = st_addr + AW'(k);
        if (a[AW-1:OFFW] == st_addr[AW-1:OFFW]) begin
          m_data[a[OFFW-1:0]] = st_wdata[8*k +: 8];
          m_mask[a[OFFW-1:0]] = 1'b1;
        end else begin
          s_data[a[OFFW-1:0]] = st_wdata[8*k +: 8];
          s_mask[a[OFFW-1:0]] = 1'b1;
          s_line = a[AW-1:OFFW];
        end
      end
    end
  endfunction

  function automatic void enter_drain();
    wr_t e;
    e.line = m_line;
    e.mask = m_mask;
    for (int i = 0; i < LB; i++) e.data[8*i +: 8] = m_data[i];
    exp_q.push_back(e);
    ms = M_DRAIN;
  endfunction

  function automatic void model_step();
    bit rdy, acc, trig;
    m_acc = 1'b0;
    if (rst) begin
      if (ms == M_DRAIN) exp_q.delete(exp_q.size() - 1);
      ms = M_EMPTY;
      m_mask = '0;
      s_mask = '0;
      idle = 0;
      return;
    end
    rdy = m_ready();
    acc = st_valid && rdy;
    m_acc = acc;
    case (ms)
      M_EMPTY: begin
        if (acc) begin
          m_mask = '0;
          m_line = st_addr[AW-1:OFFW];
          apply_store();
          idle = 0;
          if (s_mask != 0 || &m_mask) enter_drain();
          else ms = M_OPEN;
        end
      end
      M_OPEN: begin
        trig = flush || (st_valid && !rdy);
        if (acc) begin
          apply_store();
          idle = 0;
          trig = trig || (s_mask != 0) || (&m_mask);
        end else begin
          if (TO != 0 && idle == TO - 1) trig = 1'b1;
          idle++;
        end
        if (trig) enter_drain();
      end
      default: begin
        if (wr_ready) begin
          if (s_mask != 0) begin
            for (int i = 0; i < LB; i++) m_data[i] = s_data[i];
            m_mask = s_mask;
            m_line = s_line;
            s_mask = '0;
            idle = 0;
            ms = M_OPEN;
          end else begin
            m_mask = '0;
            ms = M_EMPTY;
          end
        end
      end
    endcase
  endfunction

  // Monitor: every write handshake is matched against the oldest prediction.
  always @(negedge clk) begin
    if (!rst && wr_valid === 1'b1 && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got line %0h mask %0h, wanted no write", wr_line_addr, wr_byte_mask);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_line_addr", wr_line_addr, mon_e.line);
        chk("wr_byte_mask", wr_byte_mask, mon_e.mask);
        chk("wr_data", wr_data & byte_mask(mon_e.mask), mon_e.data & byte_mask(mon_e.mask));
      end
    end
  end

  task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [WB-1:0] be,
                     input logic [8*WB-1:0] d, input bit fl, input bit wrdy, input bit r);
    st_valid = v;
    st_addr = a;
    st_byte_enable = be;
    st_wdata = d;
    flush = fl;
    wr_ready = wrdy;
    rst = r;
    @(negedge clk);
    chk("st_ready", st_ready, m_ready());
    if (!r) begin
      chk("wr_valid", wr_valid, ms == M_DRAIN);
      chk("empty", empty, ms == M_EMPTY);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [WB-1:0] be, input logic [8*WB-1:0] d,
                       input bit wrdy, output int n);
    n = 0;
    do begin
      cyc(1'b1, a, be, d, 1'b0, wrdy, 1'b0);
      n++;
    end while (!m_acc && n < 40);
    chk("store_accepted", m_acc, 1'b1);
  endtask

  task automatic idle_cyc(input int cnt, input bit fl, input bit wrdy);
    repeat (cnt) cyc(1'b0, '0, '0, '0, fl, wrdy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, wanted finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit pend;
    logic [AW-1:0] pa;
    logic [WB-1:0] pbe;
    logic [8*WB-1:0] pd;
    logic [LW-1:0] ln;
    logic [8*LB-1:0] hold_d;
    logic [LB-1:0] hold_m;
    logic [LW-1:0] hold_l;
    int sel;

    for (int i = 0; i < LB; i++) begin
      m_data[i] = 8'h00;
      s_data[i] = 8'h00;
    end
    @(posedge clk);
    #1;
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_mask", wr_byte_mask, '0);
    chk("rst_data", wr_data, '0);
    chk("rst_line", wr_line_addr, '0);

    // aligned word, flush
    store(32'h100, 4'hF, 32'hDDCCBBAA, 1'b0, n);
    idle_cyc(1, 1'b1, 1'b0);
    chk("t1_valid", wr_valid, 1'b1);
    chk("t1_line", wr_line_addr, 27'h8);
    chk("t1_mask", wr_byte_mask, 32'h0000000F);
    chk("t1_data", wr_data[31:0], 32'hDDCCBBAA);
    idle_cyc(1, 1'b0, 1'b1);

    // line-crossing store and its spill line
    store(32'h11E, 4'hF, 32'h44332211, 1'b0, n);
    chk("t2_valid", wr_valid, 1'b1);
    chk("t2_line", wr_line_addr, 27'h8);
    chk("t2_mask", wr_byte_mask, 32'hC0000000);
    chk("t2_data", wr_data[255:240], 16'h2211);
    idle_cyc(1, 1'b0, 1'b1);
    chk("t2_spill_open", wr_valid, 1'b0);
    chk("t2_spill_line", wr_line_addr, 27'h9);
    chk("t2_spill_mask", wr_byte_mask, 32'h3);
    chk("t2_spill_data", wr_data[15:0], 16'h4433);
    idle_cyc(1, 1'b1, 1'b0);
    chk("t2_spill_drain", wr_valid, 1'b1);
    idle_cyc(1, 1'b0, 1'b1);
    store(32'hFFFFFFFE, 4'hF, 32'h44332211, 1'b0, n);
    chk("t2_top_line", wr_line_addr, 27'h7FFFFFF);
    idle_cyc(1, 1'b0, 1'b1);
    chk("t2_wrap_line", wr_line_addr, 27'h0);
    chk("t2_wrap_mask", wr_byte_mask, 32'h3);
    idle_cyc(1, 1'b1, 1'b1);
    idle_cyc(1, 1'b0, 1'b1);

    // overlapping stores: newer byte wins
    store(32'h104, 4'b0011, 32'h0000BEEF, 1'b0, n);
    store(32'h104, 4'b0010, 32'h0000AA00, 1'b0, n);
    idle_cyc(1, 1'b1, 1'b0);
    chk("t3_mask", wr_byte_mask, 32'h30);
    chk("t3_data", wr_data[47:32], 16'hAAEF);
    idle_cyc(1, 1'b0, 1'b1);

    // conflicting line stalls, outputs hold while wr_ready is low
    store(32'h100, 4'hF, 32'h12345678, 1'b0, n);
    cyc(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    chk("t4_drain", wr_valid, 1'b1);
    hold_d = wr_data;
    hold_m = wr_byte_mask;
    hold_l = wr_line_addr;
    repeat (3) begin
      cyc(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      chk("t4_hold_valid", wr_valid, 1'b1);
      chk("t4_hold_data", wr_data, hold_d);
      chk("t4_hold_mask", wr_byte_mask, hold_m);
      chk("t4_hold_line", wr_line_addr, hold_l);
    end
    cyc(1'b1, 32'h200, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
    store(32'h200, 4'hF, 32'hCAFEF00D, 1'b0, n);
    chk("t4_accept_cycles", n, 1);
    idle_cyc(1, 1'b1, 1'b0);
    idle_cyc(1, 1'b0, 1'b1);

    // full line drains without flush, then idle timeout
    for (int i = 0; i < 8; i++) store(32'h100 + 32'(4 * i), 4'hF, $urandom, 1'b0, n);
    chk("t5_full_valid", wr_valid, 1'b1);
    chk("t5_full_mask", wr_byte_mask, 32'hFFFFFFFF);
    idle_cyc(1, 1'b0, 1'b1);
    store(32'h140, 4'h1, 32'h0000005A, 1'b0, n);
    k = 0;
    while (wr_valid !== 1'b1 && k < 20) begin
      idle_cyc(1, 1'b0, 1'b0);
      k++;
    end
    chk("t5_timeout_cycles", k, 4);
    idle_cyc(1, 1'b0, 1'b1);

    // reset mid-drain discards the line
    store(32'h100, 4'hF, 32'h01020304, 1'b0, n);
    idle_cyc(1, 1'b1, 1'b0);
    chk("t6_pre_valid", wr_valid, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("t6_valid", wr_valid, 1'b0);
    chk("t6_empty", empty, 1'b1);
    idle_cyc(3, 1'b1, 1'b1);
    chk("t6_no_write", wr_valid, 1'b0);

    // randomized traffic; a request is held until accepted
    pend = 1'b0;
    pa = '0;
    pbe = '0;
    pd = '0;
    for (int it = 0; it < 4000; it++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        sel = $urandom_range(0, 7);
        if (sel < 6) ln = LW'(8 + sel % 3);
        else if (sel == 6) ln = 27'h7FFFFFF;
        else ln = 27'h0;
        pa = {ln, 5'($urandom_range(0, 31))};
        pbe = 4'($urandom_range(0, 15));
        pd = $urandom;
        pend = 1'b1;
      end
      cyc(pend, pa, pbe, pd, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 399) == 0);
      if (m_acc) pend = 1'b0;
    end

    k = 0;
    while ((exp_q.size() != 0 || ms != M_EMPTY) && k < 100) begin
      idle_cyc(1, 1'b1, 1'b1);
      k++;
    end
    chk("final_drain", k < 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
